// File: rtl/gpr_file_ctrl.sv
// gpr_file_ctrl: parametrised general-purpose register file with a command
// port (NOP/READ/WRITE/CLEAR/MOVE/CLEAR_ALL/SWAP/illegal), an accumulator
// write port into R0 and two ALU operand outputs.
//
// Optional feature: define GPR_BYPASS_EN to forward the same-cycle R0 /
// R[ALU_B_REG] write data onto alu_a_o / alu_b_o combinationally.
//
// Handshake: a command transfers on a rising edge where cmd_valid_i and
// cmd_ready_o are both high; a source that sees cmd_ready_o low keeps the
// same command (and its fields) stable until it transfers.
module gpr_file_ctrl #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 3,
  parameter int ALU_B_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_mode_i,
  input  logic [ADDR_W-1:0]    src_addr_i,
  input  logic [ADDR_W-1:0]    dst_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  output logic [WORD_SIZE-1:0] rd_data_o,
  output logic                 rd_valid_o,
  input  logic                 acc_we_i,
  input  logic [WORD_SIZE-1:0] acc_in_i,
  input  logic                 alu_b_sel_i,
  output logic [WORD_SIZE-1:0] alu_a_o,
  output logic [WORD_SIZE-1:0] alu_b_o,
  output logic                 illegal_cmd_o,
  output logic                 busy_o,
  output logic                 dbg_state_o,
  output logic [ADDR_W:0]      dbg_clr_cnt_o
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] B_IDX    = ADDR_W'(ALU_B_REG);

  localparam logic [2:0] M_NOP       = 3'b000;
  localparam logic [2:0] M_READ      = 3'b001;
  localparam logic [2:0] M_WRITE     = 3'b010;
  localparam logic [2:0] M_CLEAR     = 3'b011;
  localparam logic [2:0] M_MOVE      = 3'b100;
  localparam logic [2:0] M_CLEAR_ALL = 3'b101;
  localparam logic [2:0] M_SWAP      = 3'b110;
  localparam logic [2:0] M_ILLEGAL   = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CLR  = 1'b1
  } state_t;

  state_t                 state_q;
  logic [ADDR_W:0]        clr_cnt_q;
  logic [WORD_SIZE-1:0]   rd_data_q;
  logic                   rd_valid_q;
  logic                   illegal_q;
  logic [WORD_SIZE-1:0]   regs_q [NUM_REGS];
  logic [WORD_SIZE-1:0]   cmd_d  [NUM_REGS];
  logic [WORD_SIZE-1:0]   regs_d [NUM_REGS];
  logic                   xfer;

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q == S_CLR);
  assign xfer          = cmd_valid_i & cmd_ready_o;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign illegal_cmd_o = illegal_q;
  assign dbg_state_o   = state_q;
  assign dbg_clr_cnt_o = clr_cnt_q;

  // Register contents after the effect of the accepted command only
  // (reads always use the pre-edge array, so SWAP/MOVE see old values).
  always_comb begin
    cmd_d = regs_q;
    if (xfer) begin
      case (cmd_mode_i)
        M_WRITE: cmd_d[dst_addr_i] = wr_data_i;
        M_CLEAR: cmd_d[dst_addr_i] = '0;
        M_MOVE:  cmd_d[dst_addr_i] = regs_q[src_addr_i];
        M_SWAP: begin
          cmd_d[src_addr_i] = regs_q[dst_addr_i];
          cmd_d[dst_addr_i] = regs_q[src_addr_i];
        end
        default: ;
      endcase
    end
  end

  // Full next-state array: sweep clear, then the accumulator write last so
  // it wins over any same-edge command or sweep write to R0.
  always_comb begin
    regs_d = cmd_d;
    if (state_q == S_CLR) begin
      regs_d[clr_cnt_q[ADDR_W-1:0]] = '0;
    end
    if (acc_we_i) begin
      regs_d[0] = acc_in_i;
    end
  end

`ifdef GPR_BYPASS_EN
  logic [WORD_SIZE-1:0] byp_a;
  logic [WORD_SIZE-1:0] byp_b;

  // Zero-latency operand forwarding of pending command / accumulator writes.
  always_comb begin
    byp_a = acc_we_i ? acc_in_i : cmd_d[0];
    byp_b = cmd_d[B_IDX];
    if (acc_we_i && (B_IDX == '0)) begin
      byp_b = acc_in_i;
    end
  end

  assign alu_a_o = byp_a;
  assign alu_b_o = alu_b_sel_i ? byp_b : '0;
`else
  assign alu_a_o = regs_q[0];
  assign alu_b_o = alu_b_sel_i ? regs_q[B_IDX] : '0;
`endif

  // Control FSM, registered read/illegal outputs and the register array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q     <= regs_d;
      rd_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            case (cmd_mode_i)
              M_READ: begin
                rd_data_q  <= regs_q[src_addr_i];
                rd_valid_q <= 1'b1;
              end
              M_CLEAR_ALL: begin
                state_q   <= S_CLR;
                clr_cnt_q <= '0;
              end
              M_ILLEGAL: illegal_q <= 1'b1;
              default: ;
            endcase
          end
        end
        S_CLR: begin
          if (clr_cnt_q == LAST_CNT) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  // M_NOP needs no action; the constant documents the full encoding.
  logic unused_nop;
  assign unused_nop = ^M_NOP;

endmodule
